// File: rtl/l1_access_ctrl.sv
// Purpose : serialise CPU reads/writes into L1 lookups, refill L1 from L2 on read miss, write through to L2.
// Latency : read hit done in cycle 3, read miss 4+k, write 3+k (k = L2_ACC cycle carrying l2_ack).
// Backpres: one request in flight; cpu_req is sampled only in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   cpu_req/wren/addr/wdata          CPU request (sampled in IDLE)
//   cpu_busy/done/rdata/hit/err      CPU status; rdata/hit/err valid with the done pulse
//   l1_en/wren/addr/data, l1_hit/q   L1 command and its registered result
//   l2_req/wren/addr/wdata           L2 command, held as a level until ack or timeout
//   l2_ack, l2_rdata                 L2 completion pulse and read data
//   cnt_clr, hit_cnt, miss_cnt       saturating performance counters
module l1_access_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 8,
  parameter int L2_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_err,
  output logic              l1_en,
  output logic              l1_wren,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [DATA_W-1:0] l1_data,
  input  logic              l1_hit,
  input  logic [DATA_W-1:0] l1_q,
  output logic              l2_req,
  output logic              l2_wren,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  // Timeout counter only has to reach L2_TIMEOUT-1.
  localparam int TMO_W = (L2_TIMEOUT > 2) ? $clog2(L2_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_L2_ACC,
    S_FILL,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               req_wren;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [DATA_W-1:0]  rdata_q;
  logic               hit_q;
  logic               err_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_expired;

  // High during the L2_TIMEOUT-th L2_ACC cycle; an ack in that same cycle still wins.
  assign tmo_expired = (tmo_cnt == TMO_W'(L2_TIMEOUT - 1));

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_CHECK;
      S_CHECK: begin
        if (!req_wren && l1_hit) state_nxt = S_DONE;
        else                     state_nxt = S_L2_ACC;
      end
      S_L2_ACC: begin
        if (l2_ack)           state_nxt = req_wren ? S_DONE : S_FILL;
        else if (tmo_expired) state_nxt = S_DONE;
      end
      S_FILL:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Everything is decoded from registered state so reset clears the outputs
  // immediately, including an l2_req that is mid-transaction.
  always_comb begin
    cpu_busy  = (state != S_IDLE);
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    cpu_hit   = 1'b0;
    cpu_err   = 1'b0;
    l1_en     = 1'b0;
    l1_wren   = 1'b0;
    l1_addr   = '0;
    l1_data   = '0;
    l2_req    = 1'b0;
    l2_wren   = 1'b0;
    l2_addr   = '0;
    l2_wdata  = '0;
    case (state)
      S_LOOKUP: begin
        l1_en   = 1'b1;
        l1_wren = req_wren;
        l1_addr = req_addr;
        l1_data = req_wdata;
      end
      S_L2_ACC: begin
        l2_req   = 1'b1;
        l2_wren  = req_wren;
        l2_addr  = req_addr;
        l2_wdata = req_wdata;
      end
      S_FILL: begin
        l1_en   = 1'b1;
        l1_wren = 1'b1;
        l1_addr = req_addr;
        l1_data = rdata_q;
      end
      S_DONE: begin
        cpu_done  = 1'b1;
        cpu_rdata = rdata_q;
        cpu_hit   = hit_q;
        cpu_err   = err_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- request datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_wren  <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_wren  <= cpu_wren;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        S_CHECK: begin
          hit_q <= l1_hit;
          // Writes echo their own data back to the CPU.
          if (req_wren)    rdata_q <= req_wdata;
          else if (l1_hit) rdata_q <= l1_q;
        end
        S_L2_ACC: begin
          if (l2_ack) begin
            if (!req_wren) rdata_q <= l2_rdata;
          end else if (tmo_expired) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cycles spent in L2_ACC; held at zero everywhere else so each access starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state != S_L2_ACC) begin
      tmo_cnt <= '0;
    end else if (!tmo_expired) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_CHECK) begin
      if (l1_hit) begin
        if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1_access_ctrl.sv
// Purpose : directed self-checking bench for l1_access_ctrl (L2_TIMEOUT overridden to 4).
// Latency : cycle numbers count from the cycle cpu_req is presented (cycle 0).
// Backpres: bench L2 acks in the k-th cycle of l2_req, or never when k = 0.
module tb_l1_access_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_wren;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [15:0] cpu_rdata;
  logic        cpu_hit;
  logic        cpu_err;
  logic        l1_en;
  logic        l1_wren;
  logic [6:0]  l1_addr;
  logic [15:0] l1_data;
  logic        l1_hit;
  logic [15:0] l1_q;
  logic        l2_req;
  logic        l2_wren;
  logic [6:0]  l2_addr;
  logic [15:0] l2_wdata;
  logic        l2_ack;
  logic [15:0] l2_rdata;
  logic        cnt_clr;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_txn.
  int          r_done_cyc;
  logic [15:0] r_rdata;
  logic        r_hit;
  logic        r_err;
  int          r_l2cnt;
  bit          r_l2bad;
  int          r_l1en_cnt;
  int          r_l1wr_cnt;
  logic [15:0] r_l1wr_data;
  bit          r_l1addr_bad;
  bit          r_busy_bad;
  logic        r_busy_after;

  l1_access_ctrl #(
    .ADDR_W(7), .DATA_W(16), .CNT_W(8), .L2_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .l1_en(l1_en), .l1_wren(l1_wren), .l1_addr(l1_addr), .l1_data(l1_data),
    .l1_hit(l1_hit), .l1_q(l1_q),
    .l2_req(l2_req), .l2_wren(l2_wren), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_rdata(l2_rdata),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one CPU transaction and records what the DUT did cycle by cycle.
  // ack_k = 0 means L2 never acks; clr_cyc = cycle whose edge sees cnt_clr=1 (-1 none).
  task automatic run_txn(input logic wren, input logic [6:0] addr, input logic [15:0] wdata,
                         input logic hit, input logic [15:0] q, input int ack_k,
                         input logic [15:0] ack_data, input bit hold_req, input bit stray_ack,
                         input int clr_cyc);
    int l2n;
    l2n          = 0;
    r_done_cyc   = -1;
    r_rdata      = 'x;
    r_hit        = 1'bx;
    r_err        = 1'bx;
    r_l2bad      = 0;
    r_l1en_cnt   = 0;
    r_l1wr_cnt   = 0;
    r_l1wr_data  = 'x;
    r_l1addr_bad = 0;
    r_busy_bad   = 0;
    l1_hit    = hit;
    l1_q      = q;
    cpu_req   = 1'b1;
    cpu_wren  = wren;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    l2_ack    = 1'b0;
    l2_rdata  = ack_data;
    cnt_clr   = (clr_cyc == 0);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (!hold_req) cpu_req = 1'b0;
      if (cpu_busy !== 1'b1) r_busy_bad = 1;
      if (l1_en === 1'b1) begin
        r_l1en_cnt++;
        if (l1_addr !== addr) r_l1addr_bad = 1;
        if (l1_wren === 1'b1) begin
          r_l1wr_cnt++;
          r_l1wr_data = l1_data;
        end
      end
      if (l2_req === 1'b1) begin
        l2n++;
        if (l2_wren !== wren || l2_addr !== addr || (wren && l2_wdata !== wdata)) r_l2bad = 1;
      end
      cnt_clr = (cyc == clr_cyc);
      if (cpu_done === 1'b1) begin
        r_done_cyc = cyc;
        r_rdata    = cpu_rdata;
        r_hit      = cpu_hit;
        r_err      = cpu_err;
        break;
      end
      l2_ack = (l2_req === 1'b1) ? (ack_k != 0 && l2n == ack_k) : stray_ack;
    end
    r_l2cnt = l2n;
    cpu_req = 1'b0;
    l2_ack  = 1'b0;
    cnt_clr = 1'b0;
    tick();
    r_busy_after = cpu_busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_req = 0; cpu_wren = 0; cpu_addr = 0; cpu_wdata = 0;
    l1_hit = 0; l1_q = 0; l2_ack = 0; l2_rdata = 0; cnt_clr = 0;
    repeat (2) tick();
    checks++; if ({cpu_busy, cpu_done, cpu_hit, cpu_err, l1_en, l1_wren, l2_req, l2_wren} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {cpu_busy, cpu_done, cpu_hit, cpu_err, l1_en, l1_wren, l2_req, l2_wren}); end
    checks++; if ({cpu_rdata, l1_data, l2_wdata, l1_addr, l2_addr} !== 62'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {cpu_rdata, l1_data, l2_wdata, l1_addr, l2_addr}); end
    checks++; if ({hit_cnt, miss_cnt} !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0000", {hit_cnt, miss_cnt}); end
    reset_n = 1'b1;
    tick();
    checks++; if (cpu_busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b want 0", cpu_busy); end
  endtask

  task automatic test_read_miss();
    run_txn(1'b0, 7'h05, 16'h0000, 1'b0, 16'h0000, 2, 16'hBEEF, 0, 0, -1);
    checks++; if (r_done_cyc !== 6) begin errors++; $display("FAIL miss_done_cyc: got %0d want 6", r_done_cyc); end
    checks++; if (r_rdata !== 16'hBEEF) begin errors++; $display("FAIL miss_rdata: got %h want beef", r_rdata); end
    checks++; if ({r_hit, r_err} !== 2'b00) begin errors++; $display("FAIL miss_flags: got %b want 00", {r_hit, r_err}); end
    checks++; if (r_l2cnt !== 2 || r_l2bad) begin errors++; $display("FAIL miss_l2: got %0d cycles bad=%0d want 2 bad=0", r_l2cnt, r_l2bad); end
    checks++; if (r_l1en_cnt !== 2 || r_l1wr_cnt !== 1 || r_l1wr_data !== 16'hBEEF || r_l1addr_bad) begin
      errors++; $display("FAIL miss_fill: got en=%0d wr=%0d data=%h addrbad=%0d want en=2 wr=1 data=beef addrbad=0",
                          r_l1en_cnt, r_l1wr_cnt, r_l1wr_data, r_l1addr_bad); end
    checks++; if (miss_cnt !== 8'd1 || hit_cnt !== 8'd0) begin
      errors++; $display("FAIL miss_cnt: got hit=%0d miss=%0d want hit=0 miss=1", hit_cnt, miss_cnt); end
    checks++; if (r_busy_bad || r_busy_after !== 1'b0) begin
      errors++; $display("FAIL miss_busy: got gap=%0d after=%b want gap=0 after=0", r_busy_bad, r_busy_after); end
  endtask

  task automatic test_read_hit();
    // Stray acks while no L2 access is open must be ignored.
    run_txn(1'b0, 7'h05, 16'h0000, 1'b1, 16'h1234, 1, 16'hDEAD, 0, 1, -1);
    checks++; if (r_done_cyc !== 3) begin errors++; $display("FAIL hit_done_cyc: got %0d want 3", r_done_cyc); end
    checks++; if (r_rdata !== 16'h1234 || r_hit !== 1'b1 || r_err !== 1'b0) begin
      errors++; $display("FAIL hit_result: got rdata=%h hit=%b err=%b want 1234 1 0", r_rdata, r_hit, r_err); end
    checks++; if (r_l2cnt !== 0 || r_l1en_cnt !== 1 || r_l1wr_cnt !== 0) begin
      errors++; $display("FAIL hit_access: got l2=%0d l1en=%0d l1wr=%0d want 0 1 0", r_l2cnt, r_l1en_cnt, r_l1wr_cnt); end
    checks++; if (hit_cnt !== 8'd1 || miss_cnt !== 8'd1) begin
      errors++; $display("FAIL hit_cnt: got hit=%0d miss=%0d want hit=1 miss=1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write();
    // cpu_req held high throughout: only the one write may be accepted.
    run_txn(1'b1, 7'h22, 16'hA5A5, 1'b0, 16'h0000, 1, 16'h0000, 1, 0, -1);
    checks++; if (r_done_cyc !== 4) begin errors++; $display("FAIL wr_done_cyc: got %0d want 4", r_done_cyc); end
    checks++; if (r_rdata !== 16'hA5A5 || r_hit !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL wr_result: got rdata=%h hit=%b err=%b want a5a5 0 0", r_rdata, r_hit, r_err); end
    checks++; if (r_l2cnt !== 1 || r_l2bad) begin errors++; $display("FAIL wr_l2: got %0d cycles bad=%0d want 1 bad=0", r_l2cnt, r_l2bad); end
    checks++; if (r_l1en_cnt !== 1 || r_l1wr_cnt !== 1 || r_l1wr_data !== 16'hA5A5) begin
      errors++; $display("FAIL wr_l1: got en=%0d wr=%0d data=%h want 1 1 a5a5", r_l1en_cnt, r_l1wr_cnt, r_l1wr_data); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL wr_no_requeue: got busy=%b want 0", r_busy_after); end
    checks++; if (miss_cnt !== 8'd2) begin errors++; $display("FAIL wr_cnt: got miss=%0d want 2", miss_cnt); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 7'h41, 16'h0000, 1'b0, 16'h0000, 0, 16'h0000, 0, 0, -1);
    checks++; if (r_done_cyc !== 7) begin errors++; $display("FAIL tmo_done_cyc: got %0d want 7", r_done_cyc); end
    checks++; if (r_err !== 1'b1 || r_hit !== 1'b0) begin errors++; $display("FAIL tmo_flags: got err=%b hit=%b want 1 0", r_err, r_hit); end
    checks++; if (r_l2cnt !== 4) begin errors++; $display("FAIL tmo_l2_cycles: got %0d want 4", r_l2cnt); end
    checks++; if (r_l1wr_cnt !== 0) begin errors++; $display("FAIL tmo_no_fill: got %0d fills want 0", r_l1wr_cnt); end
    // Ack in the very cycle the timeout expires: ack wins.
    run_txn(1'b0, 7'h41, 16'h0000, 1'b0, 16'h0000, 4, 16'h0F0F, 0, 0, -1);
    checks++; if (r_done_cyc !== 8 || r_err !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_ack: got cyc=%0d err=%b want 8 0", r_done_cyc, r_err); end
    checks++; if (r_rdata !== 16'h0F0F || r_l1wr_cnt !== 1 || r_l1wr_data !== 16'h0F0F) begin
      errors++; $display("FAIL tmo_edge_fill: got rdata=%h fills=%0d data=%h want 0f0f 1 0f0f", r_rdata, r_l1wr_cnt, r_l1wr_data); end
    checks++; if (miss_cnt !== 8'd4) begin errors++; $display("FAIL tmo_cnt: got miss=%0d want 4", miss_cnt); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 7'h10, 16'h0000, 1'b1, 16'h5555, 1, 16'h0000, 0, 0, -1);
    checks++; if (r_done_cyc !== 3 || r_rdata !== 16'h5555) begin
      errors++; $display("FAIL b2b_first: got cyc=%0d rdata=%h want 3 5555", r_done_cyc, r_rdata); end
    // Issued in the IDLE cycle right after the previous done; write hit through L2.
    run_txn(1'b1, 7'h33, 16'h7E7E, 1'b1, 16'h0000, 2, 16'h0000, 0, 0, -1);
    checks++; if (r_done_cyc !== 5 || r_hit !== 1'b1 || r_rdata !== 16'h7E7E) begin
      errors++; $display("FAIL b2b_write_hit: got cyc=%0d hit=%b rdata=%h want 5 1 7e7e", r_done_cyc, r_hit, r_rdata); end
    checks++; if (r_l2cnt !== 2 || r_l2bad) begin errors++; $display("FAIL b2b_l2: got %0d bad=%0d want 2 0", r_l2cnt, r_l2bad); end
    checks++; if (hit_cnt !== 8'd3) begin errors++; $display("FAIL b2b_cnt: got hit=%0d want 3", hit_cnt); end
  endtask

  task automatic test_reset_mid_l2();
    l1_hit = 1'b0; cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 7'h06; cpu_wdata = 16'h0;
    tick();
    cpu_req = 1'b0;
    repeat (2) tick();
    checks++; if (l2_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got l2_req=%b want 1", l2_req); end
    reset_n = 1'b0;
    #1;
    checks++; if (l2_req !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got l2_req=%b busy=%b want 0 0", l2_req, cpu_busy); end
    checks++; if (miss_cnt !== 8'd0 || hit_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
    tick();
    reset_n = 1'b1;
    tick();
    run_txn(1'b0, 7'h06, 16'h0000, 1'b1, 16'hC0DE, 1, 16'h0000, 0, 0, -1);
    checks++; if (r_done_cyc !== 3 || r_rdata !== 16'hC0DE || r_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got cyc=%0d rdata=%h err=%b want 3 c0de 0", r_done_cyc, r_rdata, r_err); end
  endtask

  task automatic test_counters();
    // hit_cnt is 1 after the previous task; 299 more hits give 300 total.
    for (int i = 0; i < 299; i++) begin
      run_txn(1'b0, 7'h01, 16'h0000, 1'b1, 16'h0001, 1, 16'h0000, 0, 0, -1);
    end
    checks++; if (hit_cnt !== 8'd255 || miss_cnt !== 8'd0) begin
      errors++; $display("FAIL cnt_saturate: got hit=%0d miss=%0d want 255 0", hit_cnt, miss_cnt); end
    // cnt_clr on the CHECK edge (cycle 2) beats that cycle's increment.
    run_txn(1'b0, 7'h01, 16'h0000, 1'b1, 16'h0001, 1, 16'h0000, 0, 0, 2);
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clr_prio: got hit=%0d want 0", hit_cnt); end
    run_txn(1'b0, 7'h01, 16'h0000, 1'b0, 16'h0000, 1, 16'h1111, 0, 0, -1);
    checks++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd1) begin
      errors++; $display("FAIL cnt_after_clr: got hit=%0d miss=%0d want 0 1", hit_cnt, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid_l2();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
